// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the 8-bit-address / 32-bit-data system bus
// copy master: FSM state encoding, decoded address map and width defaults.
package bus_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LEN_W  = 6;

  // Decoded address map: slave 0 at 0x00-0x1F, slave 1 at 0x20-0x3E.
  localparam logic [7:0] S0_BASE   = 8'h00;
  localparam logic [7:0] S1_BASE   = 8'h20;
  localparam logic [7:0] MAP_LIMIT = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_CAPT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // True when the address falls inside the decoded map (0x00-0x3E).
  function automatic logic addr_mapped(input logic [7:0] addr);
    return addr < MAP_LIMIT;
  endfunction

endpackage

// File: rtl/bus_copy_ctr.sv
// bus_copy_ctr: source/destination/index registers and address adders for
// the block copy master.
//   clk, reset_n   : clock, asynchronous active-low reset
//   load           : capture src_in/dst_in/len_in and clear the index
//   inc            : advance the element index by one
//   rd_addr        : src + idx (8-bit modulo)
//   wr_addr        : dst + idx (8-bit modulo)
//   rd_next        : src + idx + 1 (only with BUS_MASTER_ERRCHK_EN)
//   last           : idx + 1 equals the latched length
module bus_copy_ctr
  import bus_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             inc,
  input  logic [7:0]       src_in,
  input  logic [7:0]       dst_in,
  input  logic [LEN_W-1:0] len_in,
  output logic [7:0]       rd_addr,
  output logic [7:0]       wr_addr,
`ifdef BUS_MASTER_ERRCHK_EN
  output logic [7:0]       rd_next,
`endif
  output logic             last
);

  logic [7:0]       src;
  logic [7:0]       dst;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      idx <= '0;
    end else if (load) begin
      src <= src_in;
      dst <= dst_in;
      len <= len_in;
      idx <= '0;
    end else if (inc) begin
      idx <= idx_inc;
    end
  end

  always_comb begin
    idx_inc = idx + LEN_W'(1);
    rd_addr = src + 8'(idx);
    wr_addr = dst + 8'(idx);
    last    = (idx_inc == len);
  end

`ifdef BUS_MASTER_ERRCHK_EN
  assign rd_next = src + 8'(idx_inc);
`endif

endmodule

// File: rtl/bus_master_copy.sv
// bus_master_copy: bus initiator that copies `length` words from src_addr..
// to dst_addr.. (read, capture, write per element) through the arbiter.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : command pulse, accepted only when idle
//   src_addr, dst_addr  : first source/destination addresses
//   length              : number of words (0 completes without bus traffic)
//   busy, done, err     : status (done is a one-cycle pulse, err is sticky)
//   m_req, m_grant      : arbiter handshake
//   m_wr, m_addr, m_dout: bus command, decoded from state and registers
//   m_din               : read data, valid the cycle after the read address
// Optional feature: define BUS_MASTER_ERRCHK_EN to reject addresses outside
// the decoded map (>= 0x3F); otherwise err is constant 0.
module bus_master_copy
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        src_addr,
  input  logic [7:0]        dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [7:0]        m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);

  state_t            state;
  state_t            next;
  logic              load;
  logic              inc;
  logic              last;
  logic [7:0]        rd_addr;
  logic [7:0]        wr_addr;
  logic [DATA_W-1:0] data_q;
  logic              busy_d;
  logic              done_d;
  logic              m_req_d;
`ifdef BUS_MASTER_ERRCHK_EN
  logic [7:0]        rd_next;
  logic              addr_fault;
`endif

  bus_copy_ctr #(
    .LEN_W (LEN_W)
  ) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .inc     (inc),
    .src_in  (src_addr),
    .dst_in  (dst_addr),
    .len_in  (length),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
`ifdef BUS_MASTER_ERRCHK_EN
    .rd_next (rd_next),
`endif
    .last    (last)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next;
  end

  // Next-state logic. A missing grant in READ/CAPT/WRITE voids the cycle and
  // sends the element back to REQ without advancing the index. With the error
  // check enabled, the address of the upcoming READ/WRITE is vetted on the
  // transition into that state so an unmapped cycle never reaches the bus.
  always_comb begin
    next = state;
    load = 1'b0;
    inc  = 1'b0;
`ifdef BUS_MASTER_ERRCHK_EN
    addr_fault = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          next = (length == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_grant) begin
          next = ST_READ;
`ifdef BUS_MASTER_ERRCHK_EN
          if (!addr_mapped(rd_addr)) begin
            addr_fault = 1'b1;
            next       = ST_DONE;
          end
`endif
        end
      end
      ST_READ: begin
        next = m_grant ? ST_CAPT : ST_REQ;
      end
      ST_CAPT: begin
        if (!m_grant) begin
          next = ST_REQ;
        end else begin
          next = ST_WRITE;
`ifdef BUS_MASTER_ERRCHK_EN
          if (!addr_mapped(wr_addr)) begin
            addr_fault = 1'b1;
            next       = ST_DONE;
          end
`endif
        end
      end
      ST_WRITE: begin
        if (!m_grant) begin
          next = ST_REQ;
        end else begin
          inc = 1'b1;
          if (last) begin
            next = ST_DONE;
          end else begin
            next = ST_READ;
`ifdef BUS_MASTER_ERRCHK_EN
            if (!addr_mapped(rd_next)) begin
              addr_fault = 1'b1;
              next       = ST_DONE;
            end
`endif
          end
        end
      end
      ST_DONE: begin
        next = ST_IDLE;
      end
      default: begin
        next = ST_IDLE;
      end
    endcase
  end

  // Output logic: registered status is computed from the next state so it
  // lines up with the state it describes; bus command is decoded directly.
  always_comb begin
    busy_d  = (next != ST_IDLE);
    done_d  = (next == ST_DONE);
    m_req_d = (next == ST_REQ) || (next == ST_READ) ||
              (next == ST_CAPT) || (next == ST_WRITE);
    m_addr  = '0;
    m_wr    = 1'b0;
    m_dout  = '0;
    unique case (state)
      ST_READ: begin
        m_addr = rd_addr;
      end
      ST_WRITE: begin
        m_addr = wr_addr;
        m_wr   = 1'b1;
        m_dout = data_q;
      end
      default: begin
        m_addr = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      m_req  <= 1'b0;
      data_q <= '0;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      m_req <= m_req_d;
      if (state == ST_CAPT && m_grant) data_q <= m_din;
    end
  end

`ifdef BUS_MASTER_ERRCHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        err <= 1'b0;
    else if (load)       err <= 1'b0;
    else if (addr_fault) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_copy.sv
// Directed testbench for bus_master_copy: block copies with immediate grant,
// zero length, grant withheld and lost mid-element, address wrap (or the
// unmapped-address error path with BUS_MASTER_ERRCHK_EN), start while busy,
// and reset asserted mid-transfer.
module tb_bus_master_copy;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 6;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b0;
  logic              start    = 1'b0;
  logic              m_grant  = 1'b0;
  logic [7:0]        src_addr = '0;
  logic [7:0]        dst_addr = '0;
  logic [LEN_W-1:0]  length   = '0;
  logic              busy;
  logic              done;
  logic              err;
  logic              m_req;
  logic              m_wr;
  logic [7:0]        m_addr;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;

  logic [7:0]        rd_lat  = '0;
  int unsigned       wr_cnt  = 0;
  int unsigned       wr_base = 0;
  int                n_cmp   = 0;
  int                n_fail  = 0;

  bus_master_copy #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .m_req    (m_req),
    .m_grant  (m_grant),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_din    (m_din)
  );

  always #5 clk = ~clk;

  // Memory model: the word at address a reads back as mk(a), one cycle
  // after the address is on the bus.
  function automatic logic [31:0] mk(input logic [7:0] a);
    return {8'hD0, a, ~a, a ^ 8'h5A};
  endfunction

  always @(posedge clk) begin
    rd_lat <= m_addr;
    if (m_wr && m_grant) wr_cnt <= wr_cnt + 1;
  end

  assign m_din = mk(rd_lat);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns in the first cycle after it.
  task automatic go(input logic [7:0] s, input logic [7:0] d, input logic [LEN_W-1:0] l);
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  busy,   1'b0);
    chk("rst_done",  done,   1'b0);
    chk("rst_err",   err,    1'b0);
    chk("rst_req",   m_req,  1'b0);
    chk("rst_wr",    m_wr,   1'b0);
    chk("rst_addr",  m_addr, 8'h00);
    chk("rst_dout",  m_dout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 1: src 0x00 -> dst 0x20, len 4, grant high; done 14 edges after start
    m_grant = 1'b1;
    go(8'h00, 8'h20, 6'd4);
    chk("t1_busy",   busy,  1'b1);
    chk("t1_req",    m_req, 1'b1);
    chk("t1_req_wr", m_wr,  1'b0);
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("t1_rd_addr", m_addr, 8'(e));
      chk("t1_rd_wr",   m_wr,   1'b0);
      chk("t1_done_lo", done,   1'b0);
      tick();
      tick();
      chk("t1_wr_addr", m_addr, 8'h20 + 8'(e));
      chk("t1_wr_wr",   m_wr,   1'b1);
      chk("t1_wr_data", m_dout, mk(8'(e)));
    end
    tick();
    chk("t1_done",     done,  1'b1);
    chk("t1_done_req", m_req, 1'b0);
    tick();
    chk("t1_done_clr", done,  1'b0);
    chk("t1_idle",     busy,  1'b0);

    // 2: zero length completes next cycle with no bus request
    go(8'h00, 8'h20, 6'd0);
    chk("t2_done",     done,  1'b1);
    chk("t2_busy",     busy,  1'b1);
    chk("t2_req",      m_req, 1'b0);
    tick();
    chk("t2_done_clr", done,  1'b0);
    chk("t2_req_clr",  m_req, 1'b0);
    chk("t2_idle",     busy,  1'b0);

    // 3: grant withheld 5 cycles, then lost during the WRITE of element 1
    m_grant = 1'b0;
    wr_base = wr_cnt;
    go(8'h04, 8'h24, 6'd3);
    chk("t3_req", m_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_wait_req", m_req, 1'b1);
      chk("t3_wait_wr",  m_wr,  1'b0);
    end
    m_grant = 1'b1;
    tick();
    chk("t3_rd0", m_addr, 8'h04);
    tick();
    tick();
    chk("t3_wr0",      m_addr, 8'h24);
    chk("t3_wr0_data", m_dout, mk(8'h04));
    tick();
    chk("t3_rd1", m_addr, 8'h05);
    tick();
    tick();
    chk("t3_wr1_void_addr", m_addr, 8'h25);
    chk("t3_wr1_void_wr",   m_wr,   1'b1);
    m_grant = 1'b0;
    tick();
    chk("t3_lost_req",  m_req, 1'b1);
    chk("t3_lost_wr",   m_wr,  1'b0);
    chk("t3_lost_busy", busy,  1'b1);
    m_grant = 1'b1;
    tick();
    chk("t3_reread",    m_addr, 8'h05);
    chk("t3_reread_wr", m_wr,   1'b0);
    tick();
    tick();
    chk("t3_rewrite",      m_addr, 8'h25);
    chk("t3_rewrite_data", m_dout, mk(8'h05));
    tick();
    chk("t3_rd2", m_addr, 8'h06);
    tick();
    tick();
    chk("t3_wr2",      m_addr, 8'h26);
    chk("t3_wr2_data", m_dout, mk(8'h06));
    tick();
    chk("t3_done",     done, 1'b1);
    chk("t3_wr_count", wr_cnt - wr_base, 32'd3);
    tick();

`ifdef BUS_MASTER_ERRCHK_EN
    // 4: source 0xFE is unmapped: no bus cycle, err set, done still pulses
    go(8'hFE, 8'h10, 6'd3);
    chk("t4e_err_clear", err, 1'b0);
    tick();
    chk("t4e_done",     done,   1'b1);
    chk("t4e_err",      err,    1'b1);
    chk("t4e_no_wr",    m_wr,   1'b0);
    chk("t4e_req_drop", m_req,  1'b0);
    tick();
    chk("t4e_idle",     busy,   1'b0);
    chk("t4e_sticky",   err,    1'b1);
    go(8'h00, 8'h20, 6'd1);
    chk("t4e_err_cleared", err, 1'b0);
    repeat (4) tick();
    chk("t4e_done2", done, 1'b1);
    chk("t4e_err2",  err,  1'b0);
    tick();
`else
    // 4: source wraps 0xFE, 0xFF, 0x00; a start while busy is ignored
    go(8'hFE, 8'h10, 6'd3);
    tick();
    chk("t4_rd0", m_addr, 8'hFE);
    start    = 1'b1;
    length   = '0;
    src_addr = 8'h80;
    tick();
    start    = 1'b0;
    tick();
    chk("t4_wr0",      m_addr, 8'h10);
    chk("t4_wr0_data", m_dout, mk(8'hFE));
    tick();
    chk("t4_rd1", m_addr, 8'hFF);
    tick();
    tick();
    chk("t4_wr1", m_addr, 8'h11);
    tick();
    chk("t4_rd2_wrap", m_addr, 8'h00);
    tick();
    tick();
    chk("t4_wr2",      m_addr, 8'h12);
    chk("t4_wr2_data", m_dout, mk(8'h00));
    tick();
    chk("t4_done", done, 1'b1);
    chk("t4_err",  err,  1'b0);
    tick();
    chk("t4_idle", busy, 1'b0);
`endif

    // 5: reset asserted during CAPT, then a fresh transfer
    go(8'h08, 8'h28, 6'd2);
    tick();
    tick();
    chk("t5_capt_req", m_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy,   1'b0);
    chk("t5_done", done,   1'b0);
    chk("t5_err",  err,    1'b0);
    chk("t5_req",  m_req,  1'b0);
    chk("t5_wr",   m_wr,   1'b0);
    chk("t5_addr", m_addr, 8'h00);
    chk("t5_dout", m_dout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t5_idle", busy, 1'b0);
    go(8'h30, 8'h3A, 6'd1);
    tick();
    chk("t5_rd", m_addr, 8'h30);
    tick();
    tick();
    chk("t5_wr",      m_addr, 8'h3A);
    chk("t5_wr_data", m_dout, mk(8'h30));
    tick();
    chk("t5_done_pulse", done, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
